// File: rtl/sum_shift_stage_pkg.sv
// Shared types for the sum shifter stage: state and mode encodings
// plus the default datapath width.
package sum_shift_stage_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SHL = 2'b00,
        SHR = 2'b01,
        SAR = 2'b10,
        ROL = 2'b11
    } mode_e;

endpackage

// File: rtl/sum_shift_stage_shift_step.sv
// Single-bit combinational shifter: one step of the selected operation.
module shift_step
    import sum_shift_stage_pkg::*;
#(
    parameter int W = DEF_WIDTH
) (
    input  logic [W-1:0] d,
    input  mode_e        mode,
    output logic [W-1:0] q
);

    always_comb begin
        q = d;
        unique case (mode)
            SHL: q = {d[W-2:0], 1'b0};
            SHR: q = {1'b0, d[W-1:1]};
            SAR: q = {d[W-1], d[W-1:1]};
            ROL: q = {d[W-2:0], d[W-1]};
        endcase
    end

endmodule

// File: rtl/sum_shift_stage.sv
// Captures the adder sum, steps it one bit per clock, then holds it
// with oe high until the consumer acks.
module sum_shift_stage
    import sum_shift_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             ack,
    output logic [WIDTH-1:0] from_shifter,
    output logic             oe,
    output logic             busy,
    output logic             done
);

    state_e             state_q;
    mode_e              mode_q;
    logic [AMT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   data_d;
    logic               done_q;

    shift_step #(.W(WIDTH)) u_step (
        .d    (data_q),
        .mode (mode_q),
        .q    (data_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= SHL;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        data_q <= sum_in;
                        mode_q <= mode_e'(mode);
                        cnt_q  <= amount;
                        if (amount == '0) begin
                            state_q <= HOLD;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_q <= HOLD;
                        done_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    done_q <= 1'b0;
                    if (ack) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Decoded from state alone so reset releases the bus immediately.
    assign oe           = (state_q == HOLD);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign from_shifter = data_q;

endmodule

// File: tb/tb_sum_shift_stage.sv
// Randomized and directed checks of sum_shift_stage against an
// arithmetic reference of the shift/rotate rules.
module tb_sum_shift_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] sum_in;
    logic [1:0] mode;
    logic [2:0] amount;
    logic       ack;
    logic [7:0] from_shifter;
    logic       oe;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    sum_shift_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sum_in       (sum_in),
        .mode         (mode),
        .amount       (amount),
        .ack          (ack),
        .from_shifter (from_shifter),
        .oe           (oe),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model(input logic [7:0] x,
                                         input logic [1:0] m, input int n);
        int               v;
        logic signed [7:0] s;
        v = int'(x);
        s = x;
        case (m)
            2'b00:   return 8'((v << n) & 255);
            2'b01:   return 8'(v >> n);
            2'b10:   return 8'(s >>> n);
            default: return 8'(((v << n) | (v >> (8 - n))) & 255);
        endcase
    endfunction

    task automatic run_op(input logic [7:0] din, input logic [1:0] m,
                          input int n, input logic [7:0] exp,
                          input int hold, input bit glitch, input bit sa);
        sum_in = din;
        mode   = m;
        amount = 3'(n);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        sum_in = 8'($urandom);
        mode   = 2'($urandom);
        amount = 3'($urandom);
        for (int i = 0; i < n; i++) begin
            check("shift_oe", oe, 0);
            check("shift_busy", busy, 1);
            if (glitch && i == 0) begin
                start = 1'b1;
                ack   = 1'b1;
            end
            tick();
            start = 1'b0;
            ack   = 1'b0;
        end
        check("hold_oe", oe, 1);
        check("hold_busy", busy, 1);
        check("hold_done", done, 1);
        check("result", from_shifter, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("held_oe", oe, 1);
            check("held_done", done, 0);
            check("held_val", from_shifter, exp);
        end
        ack   = 1'b1;
        start = sa;
        tick();
        ack   = 1'b0;
        start = 1'b0;
        check("rel_oe", oe, 0);
        check("rel_busy", busy, 0);
        check("rel_done", done, 0);
        check("rel_val", from_shifter, exp);
        if (sa) begin
            tick();
            check("drop_busy", busy, 0);
            check("drop_val", from_shifter, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_val"}, from_shifter, 0);
        check({tag, "_oe"}, oe, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] m;
        int         n;

        rst_n  = 1'b0;
        start  = 1'b0;
        ack    = 1'b0;
        sum_in = '0;
        mode   = '0;
        amount = '0;
        #3;
        check_reset_vals("por");
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        run_op(8'hB4, 2'b10, 3, 8'hF6, 4, 1'b0, 1'b0);
        run_op(8'h81, 2'b11, 1, 8'h03, 1, 1'b0, 1'b0);
        run_op(8'h5A, 2'b11, 0, 8'h5A, 1, 1'b0, 1'b0);
        run_op(8'hFF, 2'b00, 7, 8'h80, 0, 1'b0, 1'b0);
        run_op(8'hFF, 2'b01, 7, 8'h01, 0, 1'b0, 1'b0);
        run_op(8'h3C, 2'b00, 2, 8'hF0, 1, 1'b1, 1'b0);
        run_op(8'h96, 2'b10, 1, 8'hCB, 0, 1'b0, 1'b1);

        // Reset during HOLD: oe must drop with no clock edge.
        sum_in = 8'h77;
        mode   = 2'b00;
        amount = 3'd0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("pre_rst_oe", oe, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_hold");
        #2 rst_n = 1'b1;

        // Reset at the second SHIFT cycle of amount=5.
        tick();
        sum_in = 8'h0F;
        mode   = 2'b00;
        amount = 3'd5;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_shift");
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        run_op(8'h0F, 2'b00, 5, 8'hE0, 1, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            d = 8'($urandom);
            m = 2'($urandom);
            n = int'($urandom_range(0, 7));
            run_op(d, m, n, model(d, m, n), int'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim did not finish");
        $fatal(1);
    end

endmodule
